// File: rtl/aes_pkg.sv
// AES-128 inverse-cipher constants, FSM state encoding and GF(2^8) helpers.
// Pure combinational functions; no latency, no flow control.
// Byte i of a block sits at [127-8i -: 8]; s[r,c] is byte r+4c.
package aes_pkg;

    localparam int AES_BLK = 128;
    localparam int AES_NR  = 10;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ x;
    endfunction

    function automatic logic [7:0] gmulb(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
    endfunction

    function automatic logic [7:0] gmuld(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
    endfunction

    function automatic logic [7:0] gmule(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
    endfunction

    // Row r rotates right by r: out[r,c] takes in[r,(c-r) mod 4].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmule(a0) ^ gmulb(a1) ^ gmuld(a2) ^ gmul9(a3);
            o[119-32*c -: 8] = gmul9(a0) ^ gmule(a1) ^ gmulb(a2) ^ gmuld(a3);
            o[111-32*c -: 8] = gmuld(a0) ^ gmul9(a1) ^ gmule(a2) ^ gmulb(a3);
            o[103-32*c -: 8] = gmulb(a0) ^ gmuld(a1) ^ gmul9(a2) ^ gmule(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box lookup, one byte.
// Latency: combinational. Backpressure: none.
// Table row n holds InvSbox[16n .. 16n+15].
module aes_inv_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign dout = INV_SBOX[din];

endmodule

// File: rtl/aes_decrypt_iterative.sv
// AES-128 inverse cipher, one round per clock, one block in flight at a time.
// Latency: plain_text/out_valid register 10 edges after the accepting edge; issue interval 12.
// Backpressure: result held in DONE until out_ready; in_ready low whenever busy.
module aes_decrypt_iterative
    import aes_pkg::*;
#(
    parameter int DATA_W    = AES_BLK,
    parameter int KEY_LEN   = AES_BLK,
    parameter int NO_ROUNDS = AES_NR
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        key_valid_in,
    input  logic [KEY_LEN-1:0]          cipher_key,
    input  logic [NO_ROUNDS*DATA_W-1:0] round_keys,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           cipher_text,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           plain_text,
    output logic                        key_err
);

    state_t            state;
    logic [3:0]        rnd;
    logic [DATA_W-1:0] st;
    logic [DATA_W-1:0] isr;
    logic [DATA_W-1:0] isb;
    logic [DATA_W-1:0] rk_cur;

    // Gated by reset so in_ready reads 0 while reset is held, whatever key_valid_in does.
    assign in_ready = reset && key_valid_in && (state == IDLE);

    assign isr = inv_shift_rows(st);

    for (genvar g = 0; g < 16; g++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .din  (isr[8*g +: 8]),
            .dout (isb[8*g +: 8])
        );
    end

    // Only rk1..rk9 are reachable here; rk10 and rk0 are applied outside ROUND.
    always_comb begin
        rk_cur = '0;
        for (int r = 1; r < NO_ROUNDS; r++) begin
            if (rnd == 4'(r)) rk_cur = round_keys[(NO_ROUNDS-r)*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rnd        <= '0;
            st         <= '0;
            plain_text <= '0;
            out_valid  <= 1'b0;
            key_err    <= 1'b0;
        end else begin
            key_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        st    <= cipher_text ^ round_keys[DATA_W-1:0];
                        rnd   <= 4'(NO_ROUNDS-1);
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    if (!key_valid_in) begin
                        state   <= IDLE;
                        rnd     <= '0;
                        key_err <= 1'b1;
                    end else begin
                        st <= inv_mix_columns(isb ^ rk_cur);
                        if (rnd == 4'd1) state <= FINAL;
                        else             rnd   <= rnd - 4'd1;
                    end
                end
                FINAL: begin
                    if (!key_valid_in) begin
                        state   <= IDLE;
                        rnd     <= '0;
                        key_err <= 1'b1;
                    end else begin
                        plain_text <= isb ^ cipher_key;
                        out_valid  <= 1'b1;
                        rnd        <= '0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
